// File: rtl/vga_pkg.sv
// vga_pkg: shared VRAM geometry and read-arbiter FSM encoding
package vga_pkg;
    localparam int VRAM_AW = 14;
    localparam int VRAM_DW = 32;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        DONE = 2'd2
    } arb_state_t;
endpackage

// File: rtl/sat_counter16.sv
// sat_counter16: 16-bit event counter that sticks at all-ones
module sat_counter16 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    output logic [15:0] cnt
);
    // count enabled cycles, holding at the ceiling instead of wrapping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt <= '0;
        else if (en && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
endmodule

// File: rtl/vram_rd_arbiter.sv
// vram_rd_arbiter: shares the VRAM read port, video first, CPU in idle slots (optional stats: VRAM_RD_ARBITER_STATS_EN)
module vram_rd_arbiter
    import vga_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_valid,
    output logic [DW-1:0] vid_rdata,
    input  logic          cpu_valid,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ready,
    output logic [DW-1:0] cpu_rdata,
    output logic          ram_ren,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata
`ifdef VRAM_RD_ARBITER_STATS_EN
    ,
    output logic [15:0]   cpu_stall_cnt,
    output logic [15:0]   cpu_rd_cnt
`endif
);
    arb_state_t    state, state_nxt;
    logic          cpu_issue;
    logic [AW-1:0] raddr_q;
    assign cpu_issue = state == IDLE && cpu_valid && !vid_req;
    assign vid_rdata = ram_rdata;
    // CPU handshake state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else state <= state_nxt;
    end
    // issue only from IDLE when video leaves the slot free; DONE waits for the request to drop
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = cpu_issue ? RESP : IDLE;
            RESP:    state_nxt = DONE;
            DONE:    state_nxt = cpu_valid ? DONE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    // read port mux: video always wins, otherwise the last issued address is held
    always_comb begin
        ram_ren   = resetn && (vid_req || cpu_issue);
        ram_raddr = !resetn ? '0 : vid_req ? vid_addr : cpu_issue ? cpu_addr : raddr_q;
    end
    // registered responses and the held read address
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vid_valid <= 1'b0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            raddr_q   <= '0;
        end else begin
            vid_valid <= vid_req;
            cpu_ready <= state == RESP;
            if (state == RESP) cpu_rdata <= ram_rdata;
            if (vid_req || cpu_issue) raddr_q <= vid_req ? vid_addr : cpu_addr;
        end
    end
`ifdef VRAM_RD_ARBITER_STATS_EN
    sat_counter16 u_stall_cnt (
        .clk    (clk),
        .resetn (resetn),
        .en     (state == IDLE && cpu_valid && vid_req),
        .cnt    (cpu_stall_cnt)
    );
    sat_counter16 u_rd_cnt (
        .clk    (clk),
        .resetn (resetn),
        .en     (cpu_ready),
        .cnt    (cpu_rd_cnt)
    );
`endif
endmodule

// File: tb/tb_vram_rd_arbiter.sv
// tb_vram_rd_arbiter: scoreboard bench for the VRAM read arbiter
module tb_vram_rd_arbiter;
    typedef struct {
        logic [31:0] d;
        int          lo;
        int          hi;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        vid_req = 1'b0;
    logic [13:0] vid_addr = '0;
    logic        vid_valid;
    logic [31:0] vid_rdata;
    logic        cpu_valid = 1'b0;
    logic [13:0] cpu_addr = '0;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        ram_ren;
    logic [13:0] ram_raddr;
    logic [31:0] ram_rdata = '0;
`ifdef VRAM_RD_ARBITER_STATS_EN
    logic [15:0] cpu_stall_cnt;
    logic [15:0] cpu_rd_cnt;
`endif

    logic [31:0] mem [0:16383];
    exp_t        vq[$];
    exp_t        sq[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic        gfx_done;

    vram_rd_arbiter dut (
        .clk       (clk),
        .resetn    (resetn),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_valid (vid_valid),
        .vid_rdata (vid_rdata),
        .cpu_valid (cpu_valid),
        .cpu_addr  (cpu_addr),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .ram_ren   (ram_ren),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
`ifdef VRAM_RD_ARBITER_STATS_EN
        ,
        .cpu_stall_cnt (cpu_stall_cnt),
        .cpu_rd_cnt    (cpu_rd_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (ram_ren) ram_rdata <= mem[ram_raddr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic chk_win(input string nm, input int c, input int lo, input int hi);
        n_cmp++;
        if (c < lo || c > hi) begin
            n_fail++;
            $display("FAIL %s: at cycle %0d want %0d..%0d", nm, c, lo, hi);
        end
    endtask

    // monitor: every response the DUT presents must match the head of its queue
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (vid_valid) begin
                if (vq.size() == 0) chk("vid_spurious", 32'd1, 32'd0);
                else begin
                    e = vq.pop_front();
                    chk("vid_rdata", vid_rdata, e.d);
                    chk_win("vid_time", cyc, e.lo, e.hi);
                end
            end
            if (cpu_ready) begin
                if (sq.size() == 0) chk("cpu_spurious", 32'd1, 32'd0);
                else begin
                    e = sq.pop_front();
                    chk("cpu_rdata", cpu_rdata, e.d);
                    chk_win("cpu_time", cyc, e.lo, e.hi);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ready && n < 20);
        chk("cpu_ready_seen", {31'd0, cpu_ready}, 32'd1);
    endtask

    task automatic cpu_read(input logic [13:0] a, input int lo, input int hi);
        @(posedge clk); #1;
        cpu_valid = 1'b1;
        cpu_addr  = a;
        sq.push_back('{mem[a], cyc + lo, cyc + hi});
        wait_ready();
        @(posedge clk); #1;
        cpu_valid = 1'b0;
    endtask

    task automatic collision(input logic [13:0] va, input logic [13:0] ca);
        @(posedge clk); #1;
        vid_req   = 1'b1;
        vid_addr  = va;
        cpu_valid = 1'b1;
        cpu_addr  = ca;
        vq.push_back('{mem[va], cyc + 1, cyc + 1});
        sq.push_back('{mem[ca], cyc + 3, cyc + 3});
        @(negedge clk);
        chk("col_vid_addr", {18'd0, ram_raddr}, {18'd0, va});
        @(posedge clk); #1;
        vid_req = 1'b0;
        @(negedge clk);
        chk("col_cpu_ren", {31'd0, ram_ren}, 32'd1);
        chk("col_cpu_addr", {18'd0, ram_raddr}, {18'd0, ca});
        wait_ready();
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        int ren_cnt;
        for (int i = 0; i < 16384; i++) mem[i] = (i * 32'h01000193) ^ 32'hA5A5_0000;
        mem[14'h0010] = 32'hDEADBEEF;

        // reset with busy inputs: every output must be forced low
        vid_req   = 1'b1;
        vid_addr  = 14'h3FFF;
        cpu_valid = 1'b1;
        cpu_addr  = 14'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vid_valid", {31'd0, vid_valid}, 32'd0);
        chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_ram_ren", {31'd0, ram_ren}, 32'd0);
        chk("rst_ram_raddr", {18'd0, ram_raddr}, 32'd0);
        vid_req   = 1'b0;
        cpu_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;

        // isolated CPU read
        @(posedge clk); #1;
        cpu_valid = 1'b1;
        cpu_addr  = 14'h0010;
        sq.push_back('{32'hDEADBEEF, cyc + 2, cyc + 2});
        @(negedge clk);
        chk("iso_ren", {31'd0, ram_ren}, 32'd1);
        chk("iso_addr", {18'd0, ram_raddr}, 32'h10);
        wait_ready();
        ren_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            ren_cnt += int'(ram_ren);
        end
        chk("iso_no_reissue", ren_cnt, 32'd0);
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        @(negedge clk);
        chk("iso_addr_hold", {18'd0, ram_raddr}, 32'h10);

        // collision: video first, CPU one cycle later
        collision(14'h0100, 14'h0200);

        // video pipelined behind a CPU issue
        @(posedge clk); #1;
        cpu_valid = 1'b1;
        cpu_addr  = 14'h0300;
        sq.push_back('{mem[14'h0300], cyc + 2, cyc + 2});
        @(posedge clk); #1;
        vid_req  = 1'b1;
        vid_addr = 14'h0400;
        vq.push_back('{mem[14'h0400], cyc + 1, cyc + 1});
        @(negedge clk);
        chk("pipe_vid_addr", {18'd0, ram_raddr}, 32'h400);
        @(posedge clk); #1;
        vid_req = 1'b0;
        wait_ready();
        @(posedge clk); #1;
        cpu_valid = 1'b0;

        // gfx cadence: video every 4th cycle, 100 CPU reads within 5 cycles each
        gfx_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) cpu_read(14'($urandom_range(0, 16383)), 2, 5);
                gfx_done = 1'b1;
            end
            begin
                while (!gfx_done) begin
                    @(posedge clk); #1;
                    if (!gfx_done && cyc % 4 == 0) begin
                        vid_req  = 1'b1;
                        vid_addr = 14'($urandom_range(0, 16383));
                        vq.push_back('{mem[vid_addr], cyc + 1, cyc + 1});
                    end else vid_req = 1'b0;
                end
                vid_req = 1'b0;
            end
        join
        repeat (3) @(posedge clk);

        // reset during RESP drops the read
        @(posedge clk); #1;
        cpu_valid = 1'b1;
        cpu_addr  = 14'h0500;
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("mid_vid_valid", {31'd0, vid_valid}, 32'd0);
        chk("mid_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        chk("mid_cpu_rdata", cpu_rdata, 32'd0);
        chk("mid_ram_ren", {31'd0, ram_ren}, 32'd0);
        chk("mid_ram_raddr", {18'd0, ram_raddr}, 32'd0);
        @(negedge clk);
        chk("mid_no_ready", {31'd0, cpu_ready}, 32'd0);
        cpu_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        cpu_read(14'h0600, 2, 2);

`ifdef VRAM_RD_ARBITER_STATS_EN
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (3) collision(14'h0100, 14'h0200);
        @(negedge clk);
        chk("stat_stall3", {16'd0, cpu_stall_cnt}, 32'd3);
        chk("stat_rd3", {16'd0, cpu_rd_cnt}, 32'd3);
        @(posedge clk); #1;
        cpu_valid = 1'b1;
        cpu_addr  = 14'h0009;
        vid_addr  = 14'h0007;
        vid_req   = 1'b1;
        vq.push_back('{mem[14'h0007], cyc + 1, cyc + 1});
        for (int i = 1; i < 70000; i++) begin
            @(posedge clk); #1;
            vq.push_back('{mem[14'h0007], cyc + 1, cyc + 1});
        end
        @(posedge clk); #1;
        vid_req = 1'b0;
        sq.push_back('{mem[14'h0009], cyc + 2, cyc + 2});
        wait_ready();
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        @(negedge clk);
        chk("stat_stall_sat", {16'd0, cpu_stall_cnt}, 32'hFFFF);
        chk("stat_rd4", {16'd0, cpu_rd_cnt}, 32'd4);
`endif

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("vq_drained", vq.size(), 32'd0);
        chk("sq_drained", sq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
